// File: rtl/mtx_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : mtx_encoder
//  Brief    : Serializes a 2x2 complex matrix of 19-bit cells into a
//             cell-per-transfer stream with a configurable inter-cell gap.
//  Revision : 1.0  initial release
// ============================================================================
module mtx_encoder #(
    parameter int GAP = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic signed [18:0] matrix_in [0:1][0:1][0:1],
    output logic               busy,
    output logic               done,
    output logic signed [18:0] matrix_cell,
    output logic               imag,
    output logic               row,
    output logic               col,
    output logic               ready
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND    = 2'd1,
        S_GAPWAIT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [3:0] c_GAP = 4'(GAP);

    state_t             r_state;
    logic [2:0]         r_k;
    logic [3:0]         r_gap_cnt;
    logic signed [18:0] r_shadow [0:1][0:1][0:1];

    logic [2:0] w_k_inc;
    logic       w_accept;

    assign w_k_inc  = r_k + 3'd1;
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Shadow copy isolates the transfer in flight from later matrix_in changes.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_shadow <= matrix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_k         <= 3'd0;
            r_gap_cnt   <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ready       <= 1'b0;
            matrix_cell <= '0;
            row         <= 1'b0;
            col         <= 1'b0;
            imag        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    // Cell 0 comes straight from the input because the
                    // shadow is being written on this same edge.
                    if (start) begin
                        r_state     <= S_SEND;
                        r_k         <= 3'd0;
                        busy        <= 1'b1;
                        ready       <= 1'b1;
                        matrix_cell <= matrix_in[0][0][0];
                        row         <= 1'b0;
                        col         <= 1'b0;
                        imag        <= 1'b0;
                    end else begin
                        r_state     <= S_IDLE;
                        busy        <= 1'b0;
                        ready       <= 1'b0;
                        matrix_cell <= '0;
                        row         <= 1'b0;
                        col         <= 1'b0;
                        imag        <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (r_k == 3'd7) begin
                        r_state     <= S_DONE;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        ready       <= 1'b0;
                        matrix_cell <= '0;
                        row         <= 1'b0;
                        col         <= 1'b0;
                        imag        <= 1'b0;
                    end else if (c_GAP == 4'd0) begin
                        r_k         <= w_k_inc;
                        ready       <= 1'b1;
                        matrix_cell <= r_shadow[w_k_inc[2]][w_k_inc[1]][w_k_inc[0]];
                        row         <= w_k_inc[2];
                        col         <= w_k_inc[1];
                        imag        <= w_k_inc[0];
                    end else begin
                        r_state     <= S_GAPWAIT;
                        r_gap_cnt   <= c_GAP;
                        r_k         <= w_k_inc;
                        ready       <= 1'b0;
                        matrix_cell <= '0;
                        row         <= 1'b0;
                        col         <= 1'b0;
                        imag        <= 1'b0;
                    end
                end
                S_GAPWAIT: begin
                    if (r_gap_cnt <= 4'd1) begin
                        r_state     <= S_SEND;
                        r_gap_cnt   <= 4'd0;
                        ready       <= 1'b1;
                        matrix_cell <= r_shadow[r_k[2]][r_k[1]][r_k[0]];
                        row         <= r_k[2];
                        col         <= r_k[1];
                        imag        <= r_k[0];
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mtx_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mtx_encoder
//  Brief    : Scoreboard bench for mtx_encoder with GAP=0 and GAP=3 instances.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mtx_encoder;

    typedef logic signed [18:0] mat_t [0:1][0:1][0:1];

    typedef struct {
        int         unit;
        bit         is_done;
        int         cyc;
        logic [18:0] val;
        logic [2:0] pos;
    } ev_t;

    logic clk;
    logic reset;
    logic [1:0] start_v;
    mat_t m_in;
    logic [1:0] busy_v, done_v, ready_v, row_v, col_v, imag_v;
    logic [1:0][18:0] cell_v;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    ev_t q[$];
    logic [18:0] dec [2][2][2][2];

    mtx_encoder #(.GAP(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .matrix_in(m_in),
        .busy(busy_v[0]), .done(done_v[0]), .matrix_cell(cell_v[0]),
        .imag(imag_v[0]), .row(row_v[0]), .col(col_v[0]), .ready(ready_v[0])
    );

    mtx_encoder #(.GAP(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start_v[1]), .matrix_in(m_in),
        .busy(busy_v[1]), .done(done_v[1]), .matrix_cell(cell_v[1]),
        .imag(imag_v[1]), .row(row_v[1]), .col(col_v[1]), .ready(ready_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops one expected event per ready/done strobe.
    ev_t mon_e;
    bit  mon_ok;
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (ready_v[u] && done_v[u]) begin
                n_cmp++;
                n_err++;
                $display("FAIL overlap unit%0d cyc %0d: ready=1 done=1, required not both", u, cyc);
            end else if (ready_v[u] || done_v[u]) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected unit%0d cyc %0d: ready=%0b done=%0b val=%0d, required no event",
                             u, cyc, ready_v[u], done_v[u], $signed(cell_v[u]));
                end else begin
                    mon_e  = q.pop_front();
                    mon_ok = (mon_e.unit == u) && (mon_e.is_done == done_v[u]) &&
                             (mon_e.cyc == cyc) && (busy_v[u] == !mon_e.is_done);
                    if (!mon_e.is_done)
                        mon_ok = mon_ok && (cell_v[u] == mon_e.val) &&
                                 ({row_v[u], col_v[u], imag_v[u]} == mon_e.pos);
                    if (!mon_ok) begin
                        n_err++;
                        $display("FAIL event unit%0d cyc %0d: got done=%0b busy=%0b val=%0d pos=%03b, required unit%0d done=%0b cyc %0d val=%0d pos=%03b",
                                 u, cyc, done_v[u], busy_v[u], $signed(cell_v[u]),
                                 {row_v[u], col_v[u], imag_v[u]}, mon_e.unit, mon_e.is_done,
                                 mon_e.cyc, $signed(mon_e.val), mon_e.pos);
                    end
                end
                if (ready_v[u])
                    dec[u][row_v[u]][col_v[u]][imag_v[u]] = cell_v[u];
            end else begin
                n_cmp++;
                if (cell_v[u] !== 19'd0 || row_v[u] !== 1'b0 || col_v[u] !== 1'b0 || imag_v[u] !== 1'b0) begin
                    n_err++;
                    $display("FAIL idle_zero unit%0d cyc %0d: val=%0d pos=%03b, required 0 000",
                             u, cyc, $signed(cell_v[u]), {row_v[u], col_v[u], imag_v[u]});
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // c is the cycle in which start is driven; acceptance edge is c+1.
    task automatic push_exp(input int u, input mat_t m, input int g, input int c, input int n);
        ev_t ev;
        logic [2:0] jj;
        for (int j = 0; j < n; j++) begin
            jj         = 3'(j);
            ev.unit    = u;
            ev.is_done = 1'b0;
            ev.cyc     = c + 1 + j * (g + 1);
            ev.val     = m[jj[2]][jj[1]][jj[0]];
            ev.pos     = jj;
            q.push_back(ev);
        end
        if (n == 8) begin
            ev.unit    = u;
            ev.is_done = 1'b1;
            ev.cyc     = c + 2 + 7 * (g + 1);
            ev.val     = '0;
            ev.pos     = '0;
            q.push_back(ev);
        end
    endtask

    task automatic send(input int u, input mat_t m, input int g);
        push_exp(u, m, g, cyc, 8);
        m_in       = m;
        start_v[u] = 1'b1;
        wait_cyc(1);
        start_v[u] = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain timeout: %0d events pending, required 0", q.size());
            q.delete();
        end
        wait_cyc(4);
    endtask

    task automatic check_zero(input int u, input string name);
        n_cmp++;
        if (busy_v[u] !== 1'b0 || done_v[u] !== 1'b0 || ready_v[u] !== 1'b0 ||
            cell_v[u] !== 19'd0 || {row_v[u], col_v[u], imag_v[u]} !== 3'b000) begin
            n_err++;
            $display("FAIL %s unit%0d: busy=%0b done=%0b ready=%0b val=%0d pos=%03b, required all 0",
                     name, u, busy_v[u], done_v[u], ready_v[u], $signed(cell_v[u]),
                     {row_v[u], col_v[u], imag_v[u]});
        end
    endtask

    mat_t m_seq, m_edge, m_a, m_b;
    int   c0;

    initial begin
        reset   = 1'b0;
        start_v = 2'b00;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < 2; i++) begin
                    m_in[r][c][i]  = '0;
                    m_seq[r][c][i] = 19'(r * 4 + c * 2 + i + 1);
                    m_a[r][c][i]   = 19'(100 * (r * 4 + c * 2 + i) + 7);
                    m_b[r][c][i]   = 19'(-(50 * (r * 4 + c * 2 + i)) - 3);
                end
        m_edge[0][0][0] = 19'h40000;
        m_edge[0][0][1] = 19'h3FFFF;
        m_edge[0][1][0] = 19'd0;
        m_edge[0][1][1] = 19'h7FFFF;
        m_edge[1][0][0] = 19'd5;
        m_edge[1][0][1] = -19'sd5;
        m_edge[1][1][0] = 19'd100;
        m_edge[1][1][1] = -19'sd100;

        wait_cyc(3);
        check_zero(0, "reset_state");
        check_zero(1, "reset_state");
        reset = 1'b1;
        wait_cyc(5);

        // GAP=0 sequential values, decoder model reconstructs the matrix
        send(0, m_seq, 0);
        drain(40);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < 2; i++) begin
                    n_cmp++;
                    if (dec[0][r][c][i] !== m_seq[r][c][i]) begin
                        n_err++;
                        $display("FAIL decoder r%0d c%0d i%0d: got %0d, required %0d",
                                 r, c, i, $signed(dec[0][r][c][i]), m_seq[r][c][i]);
                    end
                end

        // GAP=3 extreme values
        send(1, m_edge, 3);
        drain(60);

        // start held high, matrix_in changed mid-transfer
        c0 = cyc;
        push_exp(0, m_a, 0, c0, 8);
        push_exp(0, m_b, 0, c0 + 9, 8);
        m_in       = m_a;
        start_v[0] = 1'b1;
        wait_cyc(4);
        m_in = m_b;
        wait_cyc(8);
        start_v[0] = 1'b0;
        drain(40);

        // reset while cell 3 is presented
        c0 = cyc;
        push_exp(0, m_a, 0, c0, 4);
        m_in       = m_a;
        start_v[0] = 1'b1;
        wait_cyc(1);
        start_v[0] = 1'b0;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(1);
        check_zero(0, "reset_abort");
        reset = 1'b1;
        wait_cyc(2);
        send(0, m_b, 0);
        drain(40);

        // start pulse while busy is ignored
        send(1, m_a, 3);
        wait_cyc(5);
        m_in       = m_b;
        start_v[1] = 1'b1;
        wait_cyc(1);
        start_v[1] = 1'b0;
        drain(60);

        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL final_queue: %0d pending, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
